// File: rtl/bitmap_rmw_pkg.sv
// Shared opcodes, FSM encoding and width helper for the page-bitmap RMW controller.
package bitmap_rmw_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitmap_rmw_ctrl_ffz_enc.sv
// Lowest-zero priority encoder: idx of the least-significant 0 bit (0 if none), full when all ones.
module ffz_enc
  import bitmap_rmw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]        word,
  output logic [clog2(DATA_WIDTH)-1:0] idx,
  output logic                         full
);

  localparam int unsigned IDX_W = clog2(DATA_WIDTH);

  // Scan high to low so the lowest zero wins the last assignment.
  always_comb begin
    idx  = '0;
    full = &word;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (!word[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bitmap_rmw_ctrl.sv
// Read-modify-write front end for the page-bitmap dpram: post-reset init sweep,
// two-stage RMW pipeline with forwarding over the RAM's read-first hazard.
module bitmap_rmw_ctrl
  import bitmap_rmw_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_data,
  output logic                         rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_old,
  output logic [DATA_WIDTH-1:0]        rsp_new,
  output logic [clog2(DATA_WIDTH)-1:0] rsp_ffz,
  output logic                         rsp_full,
  output logic [ADDR_WIDTH-1:0]        ram_addr_a,
  input  logic [DATA_WIDTH-1:0]        ram_q_a,
  output logic                         ram_wen_b,
  output logic [ADDR_WIDTH-1:0]        ram_addr_b,
  output logic [DATA_WIDTH-1:0]        ram_data_b
);

  localparam int unsigned IDX_W = clog2(DATA_WIDTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_addr;

  logic                    s1_valid;
  logic [1:0]              s1_op;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_bypass;
  logic [DATA_WIDTH-1:0]   s1_fwd_word;

  logic                    accept;
  logic                    s1_wr;
  logic                    hazard;
  logic [DATA_WIDTH-1:0]   s1_base;
  logic [DATA_WIDTH-1:0]   s1_new;
  logic [IDX_W-1:0]        ffz_idx;
  logic                    ffz_full;

  assign req_ready  = init_done;
  assign accept     = req_valid && init_done;
  assign ram_addr_a = req_addr;
  assign s1_wr      = s1_valid && (s1_op != OP_READ);
  // An accept right behind a writing S1 op to the same word would read pre-write data.
  assign hazard     = s1_wr && (s1_addr == req_addr);

  // S1 modify: base word is either the forwarded result or the RAM read.
  always_comb begin
    s1_base = s1_bypass ? s1_fwd_word : ram_q_a;
    s1_new  = s1_base;
    case (s1_op)
      OP_READ:  s1_new = s1_base;
      OP_WRITE: s1_new = s1_data;
      OP_SET:   s1_new = s1_base | s1_data;
      OP_CLR:   s1_new = s1_base & ~s1_data;
      default:  s1_new = s1_base;
    endcase
  end

  ffz_enc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ffz (
    .word (s1_new),
    .idx  (ffz_idx),
    .full (ffz_full)
  );

  // Port B is shared by the init sweep and S1 write-back; never writes while rst is high.
  always_comb begin
    ram_wen_b  = 1'b0;
    ram_addr_b = s1_addr;
    ram_data_b = s1_new;
    if (!rst) begin
      if (state == ST_INIT) begin
        ram_wen_b  = 1'b1;
        ram_addr_b = init_addr;
        ram_data_b = INIT_VALUE;
      end else if (s1_wr) begin
        ram_wen_b  = 1'b1;
      end
    end
  end

  // Init sweep FSM: one word per cycle, then RUN until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == {ADDR_WIDTH{1'b1}}) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // S0 capture into S1, and registered response from S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_op       <= OP_READ;
      s1_addr     <= '0;
      s1_data     <= '0;
      s1_bypass   <= 1'b0;
      s1_fwd_word <= '0;
      rsp_valid   <= 1'b0;
      rsp_old     <= '0;
      rsp_new     <= '0;
      rsp_ffz     <= '0;
      rsp_full    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op       <= req_op;
        s1_addr     <= req_addr;
        s1_data     <= req_data;
        s1_bypass   <= hazard;
        s1_fwd_word <= s1_new;
      end
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_old  <= s1_base;
        rsp_new  <= s1_new;
        rsp_ffz  <= ffz_idx;
        rsp_full <= ffz_full;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_rmw_ctrl.sv
// Bench for bitmap_rmw_ctrl: read-first dpram model, serial bitmap model and response scoreboard.
module tb_bitmap_rmw_ctrl;
  import bitmap_rmw_pkg::*;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_old;
  logic [DW-1:0] rsp_new;
  logic [5:0]    rsp_ffz;
  logic          rsp_full;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_q_a;
  logic          ram_wen_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b;

  typedef struct {
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    int            ffz;
    bit            full;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    int            addr;
    logic [DW-1:0] data;
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    int            ffz;
    bit            full;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            rsp_seen = 0;
  exp_t          sb[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  bit            scramble = 1'b1;

  always #5 clk = ~clk;

  bitmap_rmw_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .INIT_VALUE ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_old    (rsp_old),
    .rsp_new    (rsp_new),
    .rsp_ffz    (rsp_ffz),
    .rsp_full   (rsp_full),
    .ram_addr_a (ram_addr_a),
    .ram_q_a    (ram_q_a),
    .ram_wen_b  (ram_wen_b),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b)
  );

  // Dual-port RAM, read-first: q_a shows the word as it was before a same-edge write.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= {$urandom, $urandom};
    end else begin
      ram_q_a <= mem[ram_addr_a];
      if (ram_wen_b) mem[ram_addr_b] <= ram_data_b;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ffz_of(input logic [DW-1:0] w);
    for (int i = 0; i < int'(DW); i++) if (!w[i]) return i;
    return 0;
  endfunction

  // Serial reference: apply op to the model array and return the expected response.
  function automatic exp_t model_op(input logic [1:0] op, input int a, input logic [DW-1:0] d);
    exp_t e;
    e.old_w = mdl[a];
    case (op)
      OP_WRITE: e.new_w = d;
      OP_SET:   e.new_w = mdl[a] | d;
      OP_CLR:   e.new_w = mdl[a] & ~d;
      default:  e.new_w = mdl[a];
    endcase
    mdl[a] = e.new_w;
    e.ffz  = ffz_of(e.new_w);
    e.full = (e.new_w == {DW{1'b1}});
    return e;
  endfunction

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 new=%0h, expected no response", rsp_new);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_old", rsp_old, e.old_w);
        chk("rsp_new", rsp_new, e.new_w);
        chk("rsp_ffz", DW'(rsp_ffz), DW'(e.ffz));
        chk("rsp_full", DW'(rsp_full), DW'(e.full));
      end
    end
  end

  // Called at a negedge; presents one request for exactly one clock.
  task automatic send(input logic [1:0] op, input int a, input logic [DW-1:0] d, input exp_t e);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = AW'(a);
    req_data  = d;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Release reset at a negedge and count rising edges until init_done.
  task automatic release_and_wait_init(input string name);
    int n;
    bit found;
    n     = 0;
    found = 1'b0;
    rst   = 1'b0;
    for (int k = 1; k <= 200 && !found; k++) begin
      @(posedge clk);
      #1;
      if (init_done) begin
        n     = k;
        found = 1'b1;
      end
    end
    chk(name, DW'(n), DW'(64));
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk(name, DW'(sb.size()), DW'(0));
  endtask

  vec_t          tab[10];
  logic [DW-1:0] ones;
  logic [DW-1:0] rdat;
  logic [1:0]    rop;
  int            raddr;
  int            base_seen;

  initial begin
    ones = '1;
    tab[0] = '{OP_SET,   5, 64'h0F,      64'h0,  64'h0F, 4, 1'b0};
    tab[1] = '{OP_READ,  5, 64'h0,       64'h0F, 64'h0F, 4, 1'b0};
    tab[2] = '{OP_SET,   3, 64'h1,       64'h0,  64'h1,  1, 1'b0};
    tab[3] = '{OP_SET,   3, 64'h2,       64'h1,  64'h3,  2, 1'b0};
    tab[4] = '{OP_CLR,   3, 64'h1,       64'h3,  64'h2,  0, 1'b0};
    tab[5] = '{OP_WRITE, 9, ones,        64'h0,  ones,   0, 1'b1};
    tab[6] = '{OP_CLR,   9, 64'h8000_0000_0000_0000, ones, 64'h7FFF_FFFF_FFFF_FFFF, 63, 1'b0};
    tab[7] = '{OP_READ,  9, 64'h0,       64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 63, 1'b0};
    tab[8] = '{OP_WRITE, 3, 64'hAA,      64'h2,  64'hAA, 0, 1'b0};
    tab[9] = '{OP_SET,   3, 64'h55,      64'hAA, 64'hFF, 8, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_READ;
    req_addr  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_init_done", DW'(init_done), DW'(0));
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_wen_b", DW'(ram_wen_b), DW'(0));
    chk("rst_rsp_new", rsp_new, DW'(0));

    // Init sweep length and contents of the end addresses
    release_and_wait_init("init_len");
    send(OP_READ, 0, '0, model_op(OP_READ, 0, '0));
    send(OP_READ, 63, '0, model_op(OP_READ, 63, '0));
    idle(3);

    // Directed table, issued back to back so same-address chains hit the bypass
    for (int i = 0; i < 10; i++) begin
      void'(model_op(tab[i].op, tab[i].addr, tab[i].data));
      send(tab[i].op, tab[i].addr, tab[i].data,
           '{tab[i].old_w, tab[i].new_w, tab[i].ffz, tab[i].full});
    end
    drain("table_drain");
    idle(2);

    // Reset with one op in S1 (pending write) and one being presented
    base_seen = rsp_seen;
    req_valid = 1'b1;
    req_op    = OP_SET;
    req_addr  = AW'(7);
    req_data  = 64'hFF;
    @(negedge clk);
    rst       = 1'b1;
    req_op    = OP_WRITE;
    req_addr  = AW'(8);
    req_data  = 64'h1234;
    #1;
    chk("rst_midstream_wen_b", DW'(ram_wen_b), DW'(0));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    release_and_wait_init("reinit_len");
    chk("rst_midstream_no_rsp", DW'(rsp_seen - base_seen), DW'(0));
    send(OP_READ, 7, '0, model_op(OP_READ, 7, '0));
    send(OP_READ, 8, '0, model_op(OP_READ, 8, '0));
    send(OP_READ, 5, '0, model_op(OP_READ, 5, '0));
    send(OP_READ, 9, '0, model_op(OP_READ, 9, '0));
    send(OP_READ, 3, '0, model_op(OP_READ, 3, '0));
    drain("reinit_drain");

    // Random stream, biased toward a few hot addresses to keep the bypass busy
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else begin
        rop   = 2'($urandom_range(0, 3));
        raddr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
        case ($urandom_range(0, 7))
          0:       rdat = ones;
          1:       rdat = '0;
          2:       rdat = DW'(1) << $urandom_range(0, 63);
          default: rdat = {$urandom, $urandom};
        endcase
        send(rop, raddr, rdat, model_op(rop, raddr, rdat));
      end
    end
    drain("random_drain");
    idle(3);

    // RAM contents must equal the serial model after all write-backs land
    for (int i = 0; i < int'(DEPTH); i++) chk("ram_final", mem[i], mdl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
